// File: rtl/dino_pkg.sv
// Shared definitions for the dino runner engine.
// Contents: game state enum, LFSR tap mask and default seed, grid row indices,
// and the one-step LFSR advance helper.
package dino_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOver = 2'd2
  } game_state_e;

  // x^16+x^14+x^13+x^11+1 in shift-right Fibonacci form: taps on bits 0, 2, 3, 5.
  localparam logic [15:0] LfsrTaps    = 16'h002D;
  localparam logic [15:0] DefaultSeed = 16'hACE1;

  // Row positions inside the 2*LANE_W grid vector.
  localparam int unsigned RowGround = 0;
  localparam int unsigned RowAir    = 1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LfsrTaps), s[15:1]};
  endfunction

endpackage

// File: rtl/dino_tick_gen.sv
// Game-step prescaler for the dino runner.
// Counts 0..period-1 in every game state and emits a registered one-cycle tick
// on the terminal count. With DINO_SPEEDUP_EN defined the period shrinks by
// TICK_DIV>>3 on each bump, floored at TICK_DIV>>2, and reloads on restart;
// otherwise the period is fixed at TICK_DIV.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   restart    : one-cycle pulse on IDLE -> RUN (reloads the period)
//   bump       : one-cycle pulse when the score reaches a multiple of 16
//   tick       : one-cycle game-step strobe
module dino_tick_gen #(
  parameter int unsigned TICK_DIV = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic bump,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] period;
  logic            wrap;

`ifdef DINO_SPEEDUP_EN
  localparam logic [CntW-1:0] PeriodStep  = CntW'(TICK_DIV >> 3);
  localparam logic [CntW-1:0] PeriodFloor = CntW'(TICK_DIV >> 2);

  logic [CntW-1:0] period_q, period_d;

  always_comb begin
    period_d = period_q;
    if (restart) begin
      period_d = CntW'(TICK_DIV);
    end else if (bump) begin
      if (period_q >= PeriodFloor + PeriodStep) begin
        period_d = period_q - PeriodStep;
      end else begin
        period_d = PeriodFloor;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_q <= CntW'(TICK_DIV);
    end else begin
      period_q <= period_d;
    end
  end

  assign period = period_q;
`else
  logic unused_ctrl;
  assign unused_ctrl = restart ^ bump;
  assign period      = CntW'(TICK_DIV);
`endif

  // '>=' so a period that shrinks below the running count still wraps at once.
  always_comb begin
    wrap  = (cnt_q >= period - CntW'(1));
    cnt_d = wrap ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick  <= wrap;
    end
  end

endmodule

// File: rtl/dino_runner.sv
// Single-lane LED dino runner: jump control, LFSR obstacle spawning, collision
// detection and scoring, all advancing once per game step.
// Optional feature: DINO_SPEEDUP_EN (step period shortens as the score grows).
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   jump_button  : raw asynchronous button level
//   start        : one-cycle pulse, IDLE->RUN and OVER->IDLE
//   grid         : [2*LANE_W-1:LANE_W] air row, [LANE_W-1:0] ground row
//   collision    : high while the game is over
//   score        : obstacles cleared, saturating
//   game_state   : 0 IDLE, 1 RUN, 2 OVER
//   tick         : one-cycle game-step strobe
module dino_runner
  import dino_pkg::*;
#(
  parameter int unsigned LANE_W     = 8,
  parameter int unsigned JUMP_TICKS = 3,
  parameter int unsigned TICK_DIV   = 1_000_000,
  parameter int unsigned MIN_GAP    = 4,
  parameter int unsigned SCORE_W    = 16,
  parameter logic [15:0] SEED       = DefaultSeed
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  jump_button,
  input  logic                  start,
  output logic [2*LANE_W-1:0]   grid,
  output logic                  collision,
  output logic [SCORE_W-1:0]    score,
  output logic [1:0]            game_state,
  output logic                  tick
);

  localparam int unsigned GapW = $clog2(MIN_GAP + 1);
  localparam int unsigned AirW = $clog2(JUMP_TICKS + 1);

  game_state_e        state_q, state_d;
  logic [LANE_W-1:0]  lane_q, lane_d, lane_step;
  logic [GapW-1:0]    gap_q, gap_d, gap_step;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               air_q, air_d, air_step;
  logic [AirW-1:0]    air_cnt_q, air_cnt_d, cnt_step;
  logic [SCORE_W-1:0] score_q, score_d, score_step;
  logic [2:0]         btn_q;
  logic               pend_q, pend_d;
  logic               btn_edge, spawn, score_inc, hit, restart, bump;

  // Two synchroniser flops, third flop holds the previous level for edge detect.
  assign btn_edge = btn_q[1] & ~btn_q[2];
  assign restart  = (state_q == StIdle) & start;
  assign bump     = tick & (state_q == StRun) & score_inc & (score_step[3:0] == 4'd0);

  dino_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset   (reset),
    .restart (restart),
    .bump    (bump),
    .tick    (tick)
  );

  // Candidate values for one game step, all taken from pre-step registers.
  always_comb begin
    spawn     = lfsr_q[0] & (gap_q >= GapW'(MIN_GAP));
    lane_step = {lane_q[LANE_W-2:0], spawn};
    if (spawn) begin
      gap_step = GapW'(1);
    end else if (gap_q >= GapW'(MIN_GAP)) begin
      gap_step = gap_q;
    end else begin
      gap_step = gap_q + GapW'(1);
    end

    air_step = air_q;
    cnt_step = air_cnt_q;
    if (!air_q) begin
      if (pend_q) begin
        air_step = 1'b1;
        cnt_step = AirW'(JUMP_TICKS - 1);
      end
    end else if (air_cnt_q == '0) begin
      air_step = 1'b0;
    end else begin
      cnt_step = air_cnt_q - AirW'(1);
    end

    score_inc  = lane_q[LANE_W-1] & (score_q != '1);
    score_step = score_q + SCORE_W'(score_inc);
    hit        = lane_step[LANE_W-1] & ~air_step;
  end

  // Datapath register updates.
  always_comb begin
    lane_d    = lane_q;
    gap_d     = gap_q;
    lfsr_d    = lfsr_q;
    air_d     = air_q;
    air_cnt_d = air_cnt_q;
    score_d   = score_q;
    // A press seen on the step cycle itself is kept for the following step.
    pend_d    = tick ? btn_edge : (pend_q | btn_edge);
    unique case (state_q)
      StIdle: begin
        if (start) begin
          lane_d    = '0;
          gap_d     = GapW'(MIN_GAP);
          air_d     = 1'b0;
          air_cnt_d = '0;
          score_d   = '0;
          pend_d    = 1'b0;
        end
      end
      StRun: begin
        if (tick) begin
          lane_d    = lane_step;
          gap_d     = gap_step;
          lfsr_d    = lfsr_next(lfsr_q);
          air_d     = air_step;
          air_cnt_d = cnt_step;
          score_d   = score_step;
        end
      end
      StOver: begin
        if (start) begin
          lane_d    = '0;
          air_d     = 1'b0;
          air_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_q    <= '0;
      gap_q     <= GapW'(MIN_GAP);
      lfsr_q    <= SEED;
      air_q     <= 1'b0;
      air_cnt_q <= '0;
      score_q   <= '0;
      btn_q     <= '0;
      pend_q    <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      gap_q     <= gap_d;
      lfsr_q    <= lfsr_d;
      air_q     <= air_d;
      air_cnt_q <= air_cnt_d;
      score_q   <= score_d;
      btn_q     <= {btn_q[1:0], jump_button};
      pend_q    <= pend_d;
    end
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. start is ignored in RUN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (tick && hit) state_d = StOver;
      StOver:  if (start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    collision  = (state_q == StOver);
    game_state = state_q;
    score      = score_q;
    grid       = '0;
    grid[RowGround*LANE_W +: LANE_W]      = lane_q;
    grid[RowGround*LANE_W + LANE_W - 1]   = lane_q[LANE_W-1] | ~air_q;
    grid[RowAir*LANE_W + LANE_W - 1]      = air_q;
  end

endmodule
